// File: rtl/bingo_pkg.sv
// Shared definitions for the bingo mark scheduler: board geometry, FSM states,
// the twelve line masks and a small BCD helper.
package bingo_pkg;

    localparam int N_CELLS = 25;
    localparam int N_LINES = 12;
    localparam int CELL_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COUNT,
        DONE
    } state_e;

    // Cell i sits at bit i with i = x + 5y.
    localparam logic [N_CELLS-1:0] MASK_ROW0      = 25'h000_001F;
    localparam logic [N_CELLS-1:0] MASK_ROW1      = 25'h000_03E0;
    localparam logic [N_CELLS-1:0] MASK_ROW2      = 25'h000_7C00;
    localparam logic [N_CELLS-1:0] MASK_ROW3      = 25'h00F_8000;
    localparam logic [N_CELLS-1:0] MASK_ROW4      = 25'h1F0_0000;
    localparam logic [N_CELLS-1:0] MASK_COL0      = 25'h010_8421;
    localparam logic [N_CELLS-1:0] MASK_COL1      = 25'h021_0842;
    localparam logic [N_CELLS-1:0] MASK_COL2      = 25'h042_1084;
    localparam logic [N_CELLS-1:0] MASK_COL3      = 25'h084_2108;
    localparam logic [N_CELLS-1:0] MASK_COL4      = 25'h108_4210;
    localparam logic [N_CELLS-1:0] MASK_DIAG_MAIN = 25'h104_1041;
    localparam logic [N_CELLS-1:0] MASK_DIAG_ANTI = 25'h011_1110;

    function automatic logic [7:0] to_bcd(input logic [CELL_W-1:0] n);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(n / 5'd10);
        units = 4'(n % 5'd10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/line_mask_rom.sv
// Combinational lookup of the line masks: rows 0-4, columns 0-4, main
// diagonal, anti-diagonal; any other index yields an empty mask.
module line_mask_rom
    import bingo_pkg::*;
(
    input  logic [3:0]         line_idx,
    output logic [N_CELLS-1:0] mask
);

    // NOTE: assign a default before the case so no path leaves mask unassigned (no latch).
    always_comb begin
        mask = '0;
        case (line_idx)
            4'd0:    mask = MASK_ROW0;
            4'd1:    mask = MASK_ROW1;
            4'd2:    mask = MASK_ROW2;
            4'd3:    mask = MASK_ROW3;
            4'd4:    mask = MASK_ROW4;
            4'd5:    mask = MASK_COL0;
            4'd6:    mask = MASK_COL1;
            4'd7:    mask = MASK_COL2;
            4'd8:    mask = MASK_COL3;
            4'd9:    mask = MASK_COL4;
            4'd10:   mask = MASK_DIAG_MAIN;
            4'd11:   mask = MASK_DIAG_ANTI;
            default: mask = '0;
        endcase
    end

endmodule

// File: rtl/mark_scheduler.sv
// Arbitrates local/remote mark requests, scans the board for the number,
// marks the cell and recounts completed lines one mask per cycle.
module mark_scheduler #(
    parameter int N_CELLS = bingo_pkg::N_CELLS,
    parameter int CELL_W  = bingo_pkg::CELL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic [N_CELLS*CELL_W-1:0] map,
    input  logic                      loc_req,
    input  logic [CELL_W-1:0]         loc_num,
    output logic                      loc_ack,
    input  logic                      rem_req,
    input  logic [CELL_W-1:0]         rem_num,
    output logic                      rem_ack,
    output logic [N_CELLS-1:0]        circle,
    output logic [3:0]                line_cnt,
    output logic [7:0]                display_nums,
    output logic                      busy,
    output logic                      done,
    output logic                      hit,
    output logic                      bingo
);

    import bingo_pkg::*;

    localparam int IDX_W = $clog2(N_CELLS);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         line_idx_q;
    logic [3:0]         acc_q;
    logic [3:0]         line_cnt_q;
    logic [CELL_W-1:0]  num_q;
    logic [N_CELLS-1:0] circle_q;
    logic [7:0]         disp_q;
    logic               hit_q;
    logic               done_q;
    logic               loc_ack_q;
    logic               rem_ack_q;
    logic               prio_rem_q;

    logic [CELL_W-1:0]  cell_num;
    logic               num_valid;
    logic               cell_match;
    logic               grant_loc;
    logic               grant_rem;
    logic [N_CELLS-1:0] line_mask;
    logic               line_full;

    line_mask_rom u_line_mask_rom (
        .line_idx (line_idx_q),
        .mask     (line_mask)
    );

    // Numbers outside 1..N_CELLS never mark, even if the map happens to hold them.
    assign cell_num   = map[int'(idx_q)*CELL_W +: CELL_W];
    assign num_valid  = (num_q != '0) && (num_q <= CELL_W'(N_CELLS));
    assign cell_match = num_valid && (cell_num == num_q);
    assign line_full  = (circle_q & line_mask) == line_mask;

    assign grant_loc = loc_req && (!rem_req || !prio_rem_q);
    assign grant_rem = rem_req && (!loc_req ||  prio_rem_q);

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            line_idx_q <= '0;
            acc_q      <= '0;
            line_cnt_q <= '0;
            num_q      <= '0;
            circle_q   <= '0;
            disp_q     <= '0;
            hit_q      <= 1'b0;
            done_q     <= 1'b0;
            loc_ack_q  <= 1'b0;
            rem_ack_q  <= 1'b0;
            prio_rem_q <= 1'b0;
        end else begin
            loc_ack_q <= 1'b0;
            rem_ack_q <= 1'b0;
            done_q    <= 1'b0;
            if (clear) begin
                state_q    <= IDLE;
                circle_q   <= '0;
                line_cnt_q <= '0;
                disp_q     <= '0;
                hit_q      <= 1'b0;
                acc_q      <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (grant_loc || grant_rem) begin
                            loc_ack_q  <= grant_loc;
                            rem_ack_q  <= grant_rem;
                            num_q      <= grant_loc ? loc_num : rem_num;
                            disp_q     <= to_bcd(grant_loc ? loc_num : rem_num);
                            hit_q      <= 1'b0;
                            idx_q      <= '0;
                            prio_rem_q <= grant_loc;
                            state_q    <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (cell_match) begin
                            circle_q[idx_q] <= 1'b1;
                            hit_q           <= 1'b1;
                        end
                        if (cell_match || idx_q == IDX_W'(N_CELLS - 1)) begin
                            acc_q      <= '0;
                            line_idx_q <= '0;
                            state_q    <= COUNT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    COUNT: begin
                        if (line_full) begin
                            acc_q <= acc_q + 1'b1;
                        end
                        if (line_idx_q == 4'(N_LINES - 1)) begin
                            state_q <= DONE;
                        end else begin
                            line_idx_q <= line_idx_q + 1'b1;
                        end
                    end
                    DONE: begin
                        done_q     <= 1'b1;
                        line_cnt_q <= acc_q;
                        state_q    <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign loc_ack      = loc_ack_q;
    assign rem_ack      = rem_ack_q;
    assign circle       = circle_q;
    assign line_cnt     = line_cnt_q;
    assign display_nums = disp_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign hit          = hit_q;
    assign bingo        = (line_cnt_q >= 4'd5);

endmodule

// File: tb/tb_mark_scheduler.sv
// Directed bench for mark_scheduler: board holds number (c+5)%25+1 in cell c,
// so number n sits at cell (n+19)%25 and a hit on cell c finishes c+14 cycles after ack.
module tb_mark_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clear = 1'b0;
    logic [124:0] map;
    logic         loc_req = 1'b0;
    logic [4:0]   loc_num = '0;
    logic         rem_req = 1'b0;
    logic [4:0]   rem_num = '0;
    logic         loc_ack, rem_ack, busy, done, hit, bingo;
    logic [24:0]  circle;
    logic [3:0]   line_cnt;
    logic [7:0]   display_nums;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [24:0]  exp_circle = '0;

    mark_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .map          (map),
        .loc_req      (loc_req),
        .loc_num      (loc_num),
        .loc_ack      (loc_ack),
        .rem_req      (rem_req),
        .rem_num      (rem_num),
        .rem_ack      (rem_ack),
        .circle       (circle),
        .line_cnt     (line_cnt),
        .display_nums (display_nums),
        .busy         (busy),
        .done         (done),
        .hit          (hit),
        .bingo        (bingo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".circle"}, circle, 0);
        check({tag, ".line_cnt"}, line_cnt, 0);
        check({tag, ".display"}, display_nums, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".hit"}, hit, 0);
        check({tag, ".acks"}, {loc_ack, rem_ack}, 0);
    endtask

    // Returns the number of cycles until done, or -1 if it never came.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
    endtask

    task automatic run_op(input string tag, input bit use_rem, input logic [4:0] num,
                          input logic [7:0] exp_disp, input int exp_lat, input bit exp_hit,
                          input logic [3:0] exp_lines);
        int lat;
        if (use_rem) begin
            rem_req = 1'b1;
            rem_num = num;
        end else begin
            loc_req = 1'b1;
            loc_num = num;
        end
        @(negedge clk);
        check({tag, ".ack"}, use_rem ? rem_ack : loc_ack, 1);
        check({tag, ".other_ack"}, use_rem ? loc_ack : rem_ack, 0);
        check({tag, ".display"}, display_nums, exp_disp);
        check({tag, ".busy"}, busy, 1);
        loc_req = 1'b0;
        rem_req = 1'b0;
        wait_done(lat);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".ack_dropped"}, {loc_ack, rem_ack}, 0);
        check({tag, ".hit"}, hit, exp_hit);
        check({tag, ".circle"}, circle, exp_circle);
        check({tag, ".line_cnt"}, line_cnt, exp_lines);
        check({tag, ".bingo"}, bingo, exp_lines >= 4'd5);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".idle"}, busy, 0);
    endtask

    // Bingo build-up: cells marked in order and completed-line count after each.
    int f_cell  [18] = '{0, 1, 2, 3, 4, 6, 12, 18, 24, 8, 16, 20, 5, 10, 15, 9, 14, 19};
    int f_lines [18] = '{0, 0, 0, 0, 1, 1, 1,  1,  2,  2, 2,  3,  3, 3,  4,  5, 5,  6};

    initial begin
        int lat;
        int pulses;
        int num;

        for (int c = 0; c < 25; c++) map[c*5 +: 5] = 5'((c + 5) % 25 + 1);

        // Reset values hold before any clock edge.
        #2;
        check_reset_outputs("reset");
        check("reset.bingo", bingo, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Local 13 lives in cell 7: 8 cells scanned + 12 + 1.
        exp_circle = 25'h80;
        run_op("single_loc", 1'b0, 5'd13, 8'h13, 21, 1'b1, 4'd0);

        // Zero and out-of-range numbers scan the whole board and mark nothing.
        run_op("rem_zero", 1'b1, 5'd0, 8'h00, 38, 1'b0, 4'd0);
        run_op("rem_30", 1'b1, 5'd30, 8'h30, 38, 1'b0, 4'd0);

        // Marking an already-marked cell still reports a hit.
        run_op("repeat_13", 1'b0, 5'd13, 8'h13, 21, 1'b1, 4'd0);

        for (int i = 0; i < 18; i++) begin
            num = (f_cell[i] + 5) % 25 + 1;
            exp_circle[f_cell[i]] = 1'b1;
            run_op($sformatf("bingo_step%0d", i), (i % 2) == 1, 5'(num),
                   8'(((num / 10) << 4) | (num % 10)), f_cell[i] + 14, 1'b1, 4'(f_lines[i]));
        end

        // Simultaneous requests after reset: loc first, rem right after loc's done.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_circle = '0;
        loc_req = 1'b1; loc_num = 5'd6;
        rem_req = 1'b1; rem_num = 5'd7;
        @(negedge clk);
        check("both.loc_first", loc_ack, 1);
        check("both.rem_wait", rem_ack, 0);
        loc_req = 1'b0;
        wait_done(lat);
        check("both.loc_latency", lat, 14);
        check("both.rem_pending", rem_ack, 0);
        @(negedge clk);
        check("both.rem_ack", rem_ack, 1);
        check("both.rem_display", display_nums, 8'h07);
        rem_req = 1'b0;
        wait_done(lat);
        check("both.rem_latency", lat, 15);
        check("both.circle", circle, 25'h3);

        // A lone loc grant hands priority to rem for the next tie.
        exp_circle = 25'h7;
        run_op("rr_loc_alone", 1'b0, 5'd8, 8'h08, 16, 1'b1, 4'd0);
        loc_req = 1'b1; loc_num = 5'd9;
        rem_req = 1'b1; rem_num = 5'd10;
        @(negedge clk);
        check("rr.rem_first", rem_ack, 1);
        check("rr.loc_wait", loc_ack, 0);
        check("rr.display", display_nums, 8'h10);
        rem_req = 1'b0;
        wait_done(lat);
        check("rr.rem_latency", lat, 18);
        check("rr.circle_mid", circle, 25'h17);
        @(negedge clk);
        check("rr.loc_ack", loc_ack, 1);
        loc_req = 1'b0;
        wait_done(lat);
        check("rr.loc_latency", lat, 17);
        check("rr.circle", circle, 25'h1F);
        check("rr.row0_line", line_cnt, 1);

        // Clear during SCAN with a request pending.
        loc_req = 1'b1; loc_num = 5'd11;
        @(negedge clk);
        check("clr_scan.accept", loc_ack, 1);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1; loc_num = 5'd12;
        @(negedge clk);
        check("clr_scan.no_ack", loc_ack, 0);
        check("clr_scan.idle", busy, 0);
        check("clr_scan.circle", circle, 0);
        check("clr_scan.line_cnt", line_cnt, 0);
        check("clr_scan.display", display_nums, 0);
        check("clr_scan.hit", hit, 0);
        clear = 1'b0; loc_req = 1'b0;
        count_done(45, pulses);
        check("clr_scan.no_done", pulses, 0);

        // Clear in IDLE overrides a request; the request is served once clear drops.
        clear = 1'b1; loc_req = 1'b1; loc_num = 5'd11;
        @(negedge clk);
        check("clr_idle.no_ack", loc_ack, 0);
        check("clr_idle.idle", busy, 0);
        clear = 1'b0;
        @(negedge clk);
        check("clr_idle.served", loc_ack, 1);
        loc_req = 1'b0;
        wait_done(lat);
        check("clr_idle.latency", lat, 19);
        check("clr_idle.circle", circle, 25'h20);

        // Reset during COUNT: outputs drop without a clock edge, no done follows.
        @(negedge clk);
        loc_req = 1'b1; loc_num = 5'd12;
        @(negedge clk);
        check("rst_mid.accept", loc_ack, 1);
        loc_req = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid.in_count", busy, 1);
        check("rst_mid.marked", circle, 25'h60);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        count_done(30, pulses);
        check("rst_mid.no_done", pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
